// File: rtl/bsample_engine.sv
// rtl/bsample_engine.sv - iterated B-cell lane engine with zero or circular boundary
module bsample_engine #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 4,
    parameter bit WRAP   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  seed,
    input  logic [WIDTH-1:0]  x,
    input  logic [ITER_W-1:0] iters,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  A
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    g_q, g_d;
    logic [WIDTH-1:0]    xr_q, xr_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    rule_v;

    // Neighbour lookup: out-of-range lanes read 0, or wrap around when WRAP is set.
    function automatic logic lane_at(input logic [WIDTH-1:0] v, input int idx);
        logic bit_v;
        bit_v = 1'b0;
        if (idx >= 0 && idx < WIDTH) begin
            bit_v = v[idx];
        end else if (WRAP) begin
            bit_v = v[(idx + WIDTH) % WIDTH];
        end
        return bit_v;
    endfunction

    // One parallel application of the B-cell rule to every lane, all from the old vector.
    always_comb begin
        rule_v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rule_v[i] = (~(lane_at(g_q, i - 2) | lane_at(g_q, i + 1) | lane_at(g_q, i + 2))
                         & lane_at(g_q, i - 1))
                      | (~g_q[i] & xr_q[i])
                      | (g_q[i] & lane_at(g_q, i - 2));
        end
    end

    // Next-state logic: load on accepted start, iterate in RUN, single-cycle DONE.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        xr_d    = xr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    g_d     = seed;
                    xr_d    = x;
                    cnt_d   = iters;
                    state_d = (iters != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                g_d   = rule_v;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            g_q     <= '0;
            xr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            xr_q    <= xr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign A    = g_q;

endmodule

// File: doc/bsample_engine.md
# bsample_engine

Iterated, parametrised successor to the single-bit B-cell. Holds a WIDTH-bit lane vector `g` and applies the B-cell rule to every lane in parallel once per clock, for a programmable number of iterations, then reports the final vector with a done pulse. It sits in the bsample path between the seed/x pattern source and the result consumer. Edge lanes are handled by a selectable boundary mode, either zero-padded or circular.

## Interface

- `WIDTH`, default 8: number of lanes; legal range is WIDTH >= 5.
- `ITER_W`, default 4: width of the iteration count.
- `WRAP`, default 0: boundary mode. 0 means out-of-range neighbours read 0; 1 means neighbour indices wrap modulo WIDTH.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `seed`  in  WIDTH  initial lane vector, captured on an accepted start.
- `x`  in  WIDTH  per-lane x operand, captured on an accepted start and held for the whole run.
- `iters`  in  ITER_W  number of rule applications, captured on an accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is valid.
- `A`  out  WIDTH  registered lane vector; always equals `g`.

## Operation

- **Per-lane rule** for lane i: next_i = (~(g1|g4|g5) & g2) | (~g3 & x_i) | (g3 & g1).
  - g3 = g[i] is the middle (self) lane.
  - g1 = g[i-2], g2 = g[i-1], g4 = g[i+1], g5 = g[i+2].
  - All lanes update simultaneously from the old vector.
- **Boundary:**
  - WRAP=0: indices <0 or >WIDTH-1 read 0.
  - WRAP=1: indices are taken mod WIDTH.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - If start=1: g<=seed, xr<=x, cnt<=iters.
  - Go to RUN if iters!=0, else go to DONE.
- **RUN:**
  - Each cycle: g<=rule(g,xr), cnt<=cnt-1.
  - When cnt==1 at the edge, go to DONE.
- **DONE:** done=1 for exactly this cycle; go to IDLE next cycle. g and A are held.
- **Start outside IDLE:** ignored in RUN and DONE. There is no queuing, and seed/x/iters changes during a run have no effect.
- **Result hold:** A holds the last result indefinitely in IDLE until the next accepted start.
- **Counter:** cnt is ITER_W bits and unsigned. The maximum run is 2^ITER_W-1 iterations; cnt never underflows.

## Timing

- **Reset values:** g=0, xr=0, cnt=0, state=IDLE, busy=0, done=0, A=0.
- **Reset mid-run:** takes effect immediately and asynchronously. The run is abandoned with no done pulse. The first start after reset deasserts is accepted normally.
- **Cycle-level sequence,** with start accepted at edge T:
  - A=seed from T+1.
  - busy=1 during cycles T+1 .. T+iters.
  - done=1 in cycle T+1+iters, with A = rule applied iters times.
  - IDLE from T+2+iters; the earliest next accepted start is at that edge.
- **iters=0:** done in cycle T+1 with A=seed; busy never asserts.
- **Output relations:**
  - busy and done are mutually exclusive.
  - done is never high two consecutive cycles.
  - A changes only on start load or RUN edges.
- **Outputs are registered:** no combinational path from any input to any output.

## Test plan

- **Reset and result hold:** assert rst mid-run with WIDTH=8, iters=5, start at cycle 2 -> A=0x00, busy=0, done=0 immediately. No done pulse follows; a new start after release runs normally.
- **Zero boundary, shift:** WRAP=0, seed=0x01, x=0x00, iters=3 -> A progresses 0x01, 0x02, 0x04, 0x08. busy high 3 cycles, done in the 4th cycle after start, A=0x08 held in IDLE.
- **Boundary compare:** seed=0x00, x=0xFF, iters=2 -> A=0xFF then 0xFC with WRAP=0; A=0xFF then 0xFF with WRAP=1.
- **Wrap-around:** WRAP=1, seed=0x80, x=0x00, iters=1 -> A=0x01. With WRAP=0 and the same stimulus -> A=0x00.
- **iters=0 and maximum count:** iters=0 -> done in the cycle after start, A=seed, busy never high. iters=15 (ITER_W=4) -> exactly 15 busy cycles, then done.
- **Ignored start:** pulse start with different seed/x/iters during RUN and during DONE -> ignored, result unchanged. Start in the first IDLE cycle after done -> accepted.
